vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the VGA controller. Sits directly downstream of the pixel-rate
//  divider. Consumes a one-clock pixel strobe and produces hsync, vsync, a video-active window
//  and pixel coordinates. The frame/line pulses drive the downstream pixel/colour stage.
//  Default timing: 640x480@60, 800x525 total.
// PARAMETERS
//  CNT_W   10   width of h/v counters and coordinate outputs
//  H_VIS   640  visible pixels per line
//  H_FP    16   horizontal front porch (pixels)
//  H_SYNC  96   horizontal sync width (pixels)
//  H_BP    48   horizontal back porch (pixels); H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP
//  V_VIS   480  visible lines
//  V_FP    10   vertical front porch (lines)
//  V_SYNC  2    vertical sync width (lines)
//  V_BP    33   vertical back porch (lines); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP
//  H_POL   0    hsync active level (0 = active-low)
//  V_POL   0    vsync active level (0 = active-low)
// PORTS
//  clock        in   1      system clock; the single clock domain
//  reset        in   1      synchronous, active-high reset
//  pix_en       in   1      pixel strobe: one clock wide, at the pixel rate
//  hsync        out  1      horizontal sync, registered, level per H_POL
//  vsync        out  1      vertical sync, registered, level per V_POL
//  video_on     out  1      high while (h_count < H_VIS) && (v_count < V_VIS)
//  pixel_x      out  CNT_W  current h_count
//  pixel_y      out  CNT_W  current v_count
//  line_start   out  1      one-clock pulse when h_count becomes 0
//  frame_start  out  1      one-clock pulse when (h_count, v_count) becomes (0, 0)
// BEHAVIOUR
//  - Single clock domain. Every flop is clocked by the rising edge of clock. Reset is
//    synchronous and active-high. pix_en is a clock enable only, never a clock.
//  - Reset values:
//    - h_count = H_TOTAL-1, v_count = V_TOTAL-1 (last pixel of the frame).
//    - hsync = ~H_POL, vsync = ~V_POL, video_on = 0, line_start = 0, frame_start = 0.
//  - Reset has priority over pix_en. Reset mid-frame returns all state to the reset values on
//    the next edge; no partial line is emitted.
//  - On a clock with pix_en=1:
//    - h_count wraps H_TOTAL-1 -> 0, otherwise increments.
//    - On the h wrap, v_count wraps V_TOTAL-1 -> 0, otherwise increments.
//  - Consequence: the first pix_en after reset lands on (0,0) and fires frame_start + line_start.
//  - Output timing:
//    - All outputs are registered and decoded from the next counter values, so they are aligned
//      with pixel_x/pixel_y in the same cycle (zero lag vs. coordinates).
//    - Latency from pix_en to updated outputs: 1 clock.
//  - On a clock with pix_en=0: counters, hsync, vsync and video_on hold.
//    line_start and frame_start go to 0 (pulses last exactly one clock).
//  - hsync is active for H_VIS+H_FP <= h_count < H_VIS+H_FP+H_SYNC (default 656..751).
//  - vsync is active for V_VIS+V_FP <= v_count < V_VIS+V_FP+V_SYNC (default 490..491).
//    It spans whole lines and switches on the h wrap.
//  - pix_en asserted on every clock is legal: full-rate operation with no gaps.
//  - Arithmetic: unsigned CNT_W-bit compares. Compile-time check: H_TOTAL and V_TOTAL <= 2**CNT_W.
// STRUCTURE
//  - Package vga_timing_pkg holds:
//    - the default 640x480@60 timing constants;
//    - H_TOTAL/V_TOTAL as derived localparams;
//    - a timing-mode typedef/struct, for later modes such as 800x600.
//  - Sub-module vga_axis_counter, instantiated twice (h axis and v axis):
//    - parameters TOTAL, VIS, FP, SYNC, POL;
//    - inputs clock, reset, en;
//    - outputs count, wrap, sync, active.
//    - The v instance uses en = pix_en & h_wrap.
//  - The top level only combines the active flags and forms the start pulses.
// TESTING
//  1. Reset held 3 clocks, then pix_en every 4th clock.
//     -> The first pix_en gives pixel_x=0, pixel_y=0, frame_start=1, line_start=1, video_on=1.
//  2. Step pix_en through line 0.
//     -> hsync=1 at x=655, 0 at x=656..751, 1 at x=752; video_on falls at x=640.
//  3. Drop pix_en for 50 clocks mid-line at x=300.
//     -> All outputs frozen and both start pulses 0 for those 50 clocks.
//  4. Run a full frame with pix_en=1 continuously.
//     -> frame_start pulses exactly 420000 clocks apart.
//     -> 525 line_start pulses per frame.
//     -> 480 lines with 640 video_on clocks each.
//  5. Count vsync across the frame.
//     -> vsync=0 exactly for y=490..491 (1600 pix_en).
//     -> vsync changes only on clocks where x wraps 799->0.
//  6. Assert reset at x=300, y=100.
//     -> The next clock shows x=799, y=524, hsync=vsync=1, video_on=0.
//     -> The next pix_en gives x=0, y=0 with frame_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - raster timing constants and mode descriptor for the VGA sync generator
package vga_timing_pkg;

  localparam int DEF_CNT_W  = 10;
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam logic DEF_H_POL = 1'b0;
  localparam logic DEF_V_POL = 1'b0;

  localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Descriptor for selectable modes (e.g. 800x600) once runtime switching is added.
  typedef struct packed {
    logic [11:0] h_vis;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_vis;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h_vis: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_vis: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
    h_pol: 1'b0,    v_pol: 1'b0
  };

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered sync/active decode
module vga_axis_counter #(
  parameter int   CNT_W = 10,
  parameter int   TOTAL = 800,
  parameter int   VIS   = 640,
  parameter int   FP    = 16,
  parameter int   SYNC  = 96,
  parameter logic POL   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(VIS + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(VIS + FP + SYNC);

  logic [CNT_W-1:0] count_next;

  always_comb begin
    wrap       = en && (count == LAST);
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Flags decode the next count so they line up with the count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= LAST;
      sync   <= ~POL;
      active <= 1'b0;
    end else begin
      count  <= count_next;
      sync   <= ((count_next >= SYNC_LO) && (count_next < SYNC_HI)) ? POL : ~POL;
      active <= (count_next < VIS_END);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator: h/v axes, video window and start pulses
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W  = DEF_CNT_W,
  parameter int   H_VIS  = DEF_H_VIS,
  parameter int   H_FP   = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP   = DEF_H_BP,
  parameter int   V_VIS  = DEF_V_VIS,
  parameter int   V_FP   = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP   = DEF_V_BP,
  parameter logic H_POL  = DEF_H_POL,
  parameter logic V_POL  = DEF_V_POL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if ((H_TOT > (2 ** CNT_W)) || (V_TOT > (2 ** CNT_W))) begin : g_width_check
    $error("vga_sync_gen: CNT_W too narrow for H/V totals");
  end

  logic h_wrap, v_wrap, h_active, v_active, v_en;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(H_TOT), .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .POL(H_POL)
  ) u_h (
    .clock(clock), .reset(reset), .en(pix_en),
    .count(pixel_x), .wrap(h_wrap), .sync(hsync), .active(h_active)
  );

  // Vertical axis advances only on the horizontal wrap, so vsync changes at x=0.
  vga_axis_counter #(
    .CNT_W(CNT_W), .TOTAL(V_TOT), .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .POL(V_POL)
  ) u_v (
    .clock(clock), .reset(reset), .en(v_en),
    .count(pixel_y), .wrap(v_wrap), .sync(vsync), .active(v_active)
  );

  assign video_on = h_active & v_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: default 640x480 instance plus a reduced-size raster for frame tests
module tb_vga_sync_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;

  logic       hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;

  logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_pixel_x, s_pixel_y;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vga_sync_gen u_dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start)
  );

  // Reduced raster: 25 x 19 total, 16 x 12 visible, hsync x=18..21, vsync y=14..15.
  vga_sync_gen #(
    .CNT_W(10), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b0)
  ) u_small (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .pixel_x(s_pixel_x), .pixel_y(s_pixel_y),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  // Drives one pix_en clock; returns at the negedge where the update is visible.
  task automatic pix_step();
    pix_en = 1'b1;
    @(negedge clock);
    pix_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b0;
    idle(3);
    total++; if (pixel_x !== 10'd799 || pixel_y !== 10'd524) begin bad++;
      $display("FAIL reset_xy got=%0d,%0d exp=799,524", pixel_x, pixel_y); end
    total++; if ({hsync, vsync, video_on, line_start, frame_start} !== 5'b11000) begin bad++;
      $display("FAIL reset_flags got=%b exp=11000", {hsync, vsync, video_on, line_start, frame_start}); end
    total++; if (s_pixel_x !== 10'd24 || s_pixel_y !== 10'd18) begin bad++;
      $display("FAIL reset_small_xy got=%0d,%0d exp=24,18", s_pixel_x, s_pixel_y); end
    reset = 1'b0;
    pix_step();
    total++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin bad++;
      $display("FAIL first_xy got=%0d,%0d exp=0,0", pixel_x, pixel_y); end
    total++; if ({frame_start, line_start, video_on} !== 3'b111) begin bad++;
      $display("FAIL first_pulses got=%b exp=111", {frame_start, line_start, video_on}); end
    idle(1);
    total++; if ({frame_start, line_start} !== 2'b00) begin bad++;
      $display("FAIL pulse_width got=%b exp=00", {frame_start, line_start}); end
    idle(2);
  endtask

  task automatic test_line0();
    int coord_err = 0;
    int hs_low = 0;
    int vo_cnt = 1;
    for (int x = 1; x < 800; x++) begin
      pix_step();
      if (pixel_x !== 10'(x) || pixel_y !== 10'd0 || line_start !== 1'b0) coord_err++;
      if (hsync === 1'b0) hs_low++;
      if (video_on === 1'b1) vo_cnt++;
      if (x == 639) begin total++; if (video_on !== 1'b1) begin bad++;
        $display("FAIL vo_x639 got=%b exp=1", video_on); end end
      if (x == 640) begin total++; if (video_on !== 1'b0) begin bad++;
        $display("FAIL vo_x640 got=%b exp=0", video_on); end end
      if (x == 655) begin total++; if (hsync !== 1'b1) begin bad++;
        $display("FAIL hs_x655 got=%b exp=1", hsync); end end
      if (x == 656) begin total++; if (hsync !== 1'b0) begin bad++;
        $display("FAIL hs_x656 got=%b exp=0", hsync); end end
      if (x == 751) begin total++; if (hsync !== 1'b0) begin bad++;
        $display("FAIL hs_x751 got=%b exp=0", hsync); end end
      if (x == 752) begin total++; if (hsync !== 1'b1) begin bad++;
        $display("FAIL hs_x752 got=%b exp=1", hsync); end end
      idle(3);
    end
    total++; if (coord_err !== 0) begin bad++;
      $display("FAIL line0_coords errors=%0d exp=0", coord_err); end
    total++; if (hs_low !== 96) begin bad++;
      $display("FAIL line0_hs_low got=%0d exp=96", hs_low); end
    total++; if (vo_cnt !== 640) begin bad++;
      $display("FAIL line0_vo got=%0d exp=640", vo_cnt); end
    pix_step();
    total++; if (pixel_x !== 10'd0 || pixel_y !== 10'd1 || line_start !== 1'b1 || frame_start !== 1'b0) begin bad++;
      $display("FAIL line1_start got=%0d,%0d ls=%b fs=%b exp=0,1 ls=1 fs=0", pixel_x, pixel_y, line_start, frame_start); end
    idle(3);
  endtask

  task automatic test_freeze();
    int frozen_err = 0;
    for (int x = 1; x <= 300; x++) pix_step();
    total++; if (pixel_x !== 10'd300 || pixel_y !== 10'd1) begin bad++;
      $display("FAIL freeze_pos got=%0d,%0d exp=300,1", pixel_x, pixel_y); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (pixel_x !== 10'd300 || pixel_y !== 10'd1 ||
          {hsync, vsync, video_on, line_start, frame_start} !== 5'b11100) frozen_err++;
    end
    total++; if (frozen_err !== 0) begin bad++;
      $display("FAIL freeze_hold errors=%0d exp=0", frozen_err); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if (pixel_x !== 10'd799 || pixel_y !== 10'd524) begin bad++;
      $display("FAIL midreset_xy got=%0d,%0d exp=799,524", pixel_x, pixel_y); end
    total++; if ({hsync, vsync, video_on} !== 3'b110) begin bad++;
      $display("FAIL midreset_flags got=%b exp=110", {hsync, vsync, video_on}); end
    idle(2);
    pix_step();
    total++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_start !== 1'b1) begin bad++;
      $display("FAIL midreset_restart got=%0d,%0d fs=%b exp=0,0 fs=1", pixel_x, pixel_y, frame_start); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    int fs1 = -1, fs2 = -1;
    int ls_cnt = 0, vo_cnt = 0, vo_lines = 0, vs_low = 0, vs_edges = 0, vs_bad_edge = 0;
    logic prev_vs;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    prev_vs = 1'b1;
    pix_en = 1'b1;
    for (int c = 0; c < 1200 && fs2 < 0; c++) begin
      @(negedge clock);
      if (s_frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = c; else fs2 = c;
      end
      if (fs1 >= 0 && fs2 < 0) begin
        if (s_line_start === 1'b1) ls_cnt++;
        if (s_video_on === 1'b1) vo_cnt++;
        if (s_video_on === 1'b1 && s_pixel_x === 10'd0) vo_lines++;
        if (s_vsync === 1'b0) vs_low++;
        if (s_vsync !== prev_vs) begin
          vs_edges++;
          if (s_pixel_x !== 10'd0) vs_bad_edge++;
        end
      end
      prev_vs = s_vsync;
    end
    pix_en = 1'b0;
    total++; if (fs1 !== 0 || fs2 !== 475) begin bad++;
      $display("FAIL frame_spacing got=%0d..%0d exp=0..475", fs1, fs2); end
    total++; if (ls_cnt !== 19) begin bad++;
      $display("FAIL line_starts got=%0d exp=19", ls_cnt); end
    total++; if (vo_cnt !== 192 || vo_lines !== 12) begin bad++;
      $display("FAIL video_window got=%0d clocks %0d lines exp=192 clocks 12 lines", vo_cnt, vo_lines); end
    total++; if (vs_low !== 50) begin bad++;
      $display("FAIL vsync_low got=%0d exp=50", vs_low); end
    total++; if (vs_edges !== 2 || vs_bad_edge !== 0) begin bad++;
      $display("FAIL vsync_edges got=%0d off_wrap=%0d exp=2 off_wrap=0", vs_edges, vs_bad_edge); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_line0();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
